dmux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 4-way demux register bank (outputs A..D) between four requesters. Each cycle it grants one requester, then registers that requester's destination select and value onto the bank's select/value inputs. The bank has no write enable, so after the last accepted beat the arbiter holds its last select and value on the bank inputs. Bursts are supported: a requester keeps its grant for up to MaxBurst consecutive beats.

---
 rtl/dmux_arb_pkg.sv | 43 ++++
 rtl/dmux_rr_pick.sv | 32 +++
 rtl/dmux_rr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmux_rr_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux_arb_pkg.sv
// Shared types and the rotate-priority search used by the demux-bank arbiter.
// Latency: none (types and a combinational helper function only).
// Backpressure: not applicable; no state lives here.
package dmux_arb_pkg;

    localparam int NumReqDefault = 4;
    localparam int SelW          = 2;

    typedef logic [SelW-1:0] sel_t;
    typedef logic [1:0]      req_idx_t;

    // Result of a rotate-priority search: winning index plus a found flag.
    typedef struct packed {
        logic     found;
        req_idx_t idx;
    } pick_t;

    // IDLE: no owner. LOCK: an owner holds the grant for its burst.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // First valid requester at or after ptr, wrapping 3->0.
    // The loop walks from the farthest candidate back to ptr so that
    // the closest valid candidate is the last assignment and wins.
    function automatic pick_t rr_pick(input logic [NumReqDefault-1:0] valid,
                                      input req_idx_t                 ptr);
        pick_t    res;
        req_idx_t cand;
        res.found = 1'b0;
        res.idx   = ptr;
        for (int k = NumReqDefault - 1; k >= 0; k--) begin
            cand = ptr + req_idx_t'(k);
            if (valid[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmux_rr_pick.sv
// Rotate-priority encoder: picks the first valid requester starting at ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the pick is used.
// Ports:
//   valid - per-requester valid vector
//   ptr   - index searched first
//   grant - one-hot of the winner, all zero when nothing is valid
//   idx   - winner index (equals ptr when nothing is valid)
//   found - high when some requester is valid
module dmux_rr_pick
    import dmux_arb_pkg::*;
(
    input  logic [NumReqDefault-1:0] valid,
    input  req_idx_t                 ptr,
    output logic [NumReqDefault-1:0] grant,
    output req_idx_t                 idx,
    output logic                     found
);

    pick_t pick;

    always_comb begin
        pick  = rr_pick(valid, ptr);
        idx   = pick.idx;
        found = pick.found;
        grant = '0;
        if (pick.found) begin
            grant[pick.idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dmux_rr_arbiter.sv
// Round-robin burst arbiter driving the select/value inputs of the 4-way demux register bank.
// Latency: handshake in cycle N -> sel_o/value_o/grant_id_o registered at N+1 (bank output at N+2).
// Backpressure: req_ready_o is combinational, one-hot or zero; with no beat the outputs hold.
// Ports:
//   clk_i, rst_ni               - clock, asynchronous active-low reset
//   req_valid_i/sel_i/data_i    - per-requester request (sel 0=A .. 3=D)
//   req_ready_o                 - per-requester ready, gated low while reset is asserted
//   sel_o, value_o, grant_id_o  - registered bank select, value and last accepted requester
//   busy_o                      - high while a burst owner holds the lock
// Optional (macro DMUX_ARB_STATS_EN): stats_clr_i clears, grant_cnt_o holds saturating
//   per-requester accepted-beat counters.
module dmux_rr_arbiter
    import dmux_arb_pkg::*;
#(
    parameter int Width    = 16,
    parameter int NumReq   = NumReqDefault,
    parameter int MaxBurst = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumReq-1:0]            req_valid_i,
    input  logic [NumReq-1:0][SelW-1:0]  req_sel_i,
    input  logic [NumReq-1:0][Width-1:0] req_data_i,
    output logic [NumReq-1:0]            req_ready_o,
    output sel_t                         sel_o,
    output logic [Width-1:0]             value_o,
    output req_idx_t                     grant_id_o,
    output logic                         busy_o
`ifdef DMUX_ARB_STATS_EN
    ,
    input  logic                         stats_clr_i,
    output logic [NumReq-1:0][15:0]      grant_cnt_o
`endif
);

    // Burst counter only needs to reach MaxBurst (at most 15).
    localparam logic [3:0] MaxBurstC = 4'(MaxBurst);

    arb_state_e        state, state_d;
    req_idx_t          owner, owner_d;
    req_idx_t          ptr, ptr_d;
    logic [3:0]        cnt, cnt_d;

    logic              lock;
    req_idx_t          search_ptr;
    logic [NumReq-1:0] owner_oh;
    logic [NumReq-1:0] pick_grant;
    req_idx_t          pick_idx;
    logic              pick_found;
    req_idx_t          grant_idx;
    logic              grant_vld;

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
        lock            = (state == ST_LOCK) && req_valid_i[owner] && (cnt < MaxBurstC);
        // On release the search starts just past the old owner, which makes
        // it lowest priority and lets a new beat go out in the same cycle.
        search_ptr      = (state == ST_LOCK) ? owner + 2'd1 : ptr;
    end

    dmux_rr_pick u_pick (
        .valid (req_valid_i),
        .ptr   (search_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        // Ready is forced low during reset so an in-flight beat is never taken.
        req_ready_o = '0;
        if (rst_ni) begin
            req_ready_o = lock ? owner_oh : pick_grant;
        end
        grant_idx = lock ? owner : pick_idx;
        grant_vld = |req_ready_o;
    end

    // ------------------------------------------------------------------
    // Lock FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state;
        owner_d = owner;
        cnt_d   = cnt;
        ptr_d   = ptr;
        if (lock) begin
            cnt_d = cnt + 4'd1;
        end else begin
            if (state == ST_LOCK) begin
                ptr_d = owner + 2'd1;
            end
            if (pick_found) begin
                state_d = ST_LOCK;
                owner_d = pick_idx;
                cnt_d   = 4'd1;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
            owner <= '0;
            cnt   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_d;
            owner <= owner_d;
            cnt   <= cnt_d;
            ptr   <= ptr_d;
        end
    end

    assign busy_o = (state == ST_LOCK);

    // ------------------------------------------------------------------
    // Bank-facing output registers. The bank has no write enable, so
    // holding these on idle cycles rewrites the same value harmlessly.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_o      <= '0;
            value_o    <= '0;
            grant_id_o <= '0;
        end else if (grant_vld) begin
            sel_o      <= req_sel_i[grant_idx];
            value_o    <= req_data_i[grant_idx];
            grant_id_o <= grant_idx;
        end
    end

`ifdef DMUX_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating per-requester beat counters; clear beats an increment.
    // ------------------------------------------------------------------
    logic [NumReq-1:0] beat;
    assign beat = req_valid_i & req_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_cnt_o <= '0;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (stats_clr_i) begin
                    grant_cnt_o[i] <= '0;
                end else if (beat[i] && (grant_cnt_o[i] != 16'hFFFF)) begin
                    grant_cnt_o[i] <= grant_cnt_o[i] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmux_rr_arbiter.sv
// Self-checking bench for dmux_rr_arbiter: one instance with MaxBurst=4, one with MaxBurst=1,
// both fed by the same requester models. Expected grants come from per-test patterns;
// expected bank outputs are queued when a beat is driven and compared one cycle later.
module tb_dmux_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [3:0]       req_valid;
    logic [3:0][1:0]  req_sel;
    logic [3:0][15:0] req_data;

    logic [3:0]  rdy4, rdy1;
    logic [1:0]  sel4, sel1, id4, id1;
    logic [15:0] val4, val1;
    logic        busy4, busy1;
`ifdef DMUX_ARB_STATS_EN
    logic             stats_clr;
    logic [3:0][15:0] gc4, gc1;
`endif

    dmux_rr_arbiter #(.Width(16), .NumReq(4), .MaxBurst(4)) dut4 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_sel_i   (req_sel),
        .req_data_i  (req_data),
        .req_ready_o (rdy4),
        .sel_o       (sel4),
        .value_o     (val4),
        .grant_id_o  (id4),
        .busy_o      (busy4)
`ifdef DMUX_ARB_STATS_EN
        ,
        .stats_clr_i (stats_clr),
        .grant_cnt_o (gc4)
`endif
    );

    dmux_rr_arbiter #(.Width(16), .NumReq(4), .MaxBurst(1)) dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_sel_i   (req_sel),
        .req_data_i  (req_data),
        .req_ready_o (rdy1),
        .sel_o       (sel1),
        .value_o     (val1),
        .grant_id_o  (id1),
        .busy_o      (busy1)
`ifdef DMUX_ARB_STATS_EN
        ,
        .stats_clr_i (stats_clr),
        .grant_cnt_o (gc1)
`endif
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic [15:0] value;
        logic [1:0]  id;
        logic        busy;
    } out_t;

    out_t        sb[$];
    out_t        exp_out;
    int          pat[$];
    int          checks;
    int          errors;
    int          rem[4];
    logic [15:0] dat[4];
    logic [1:0]  sl[4];
    logic        use1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = (rem[i] > 0);
            req_sel[i]   = sl[i];
            req_data[i]  = dat[i];
        end
    endtask

    task automatic advance(input logic [3:0] hs);
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                rem[i] = rem[i] - 1;
                dat[i] = dat[i] + 16'd1;
                sl[i]  = sl[i] + 2'd1;
            end
        end
    endtask

    task automatic set_req(input int i, input int n, input logic [1:0] s, input logic [15:0] d);
        rem[i] = n;
        sl[i]  = s;
        dat[i] = d;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < 4; i++) set_req(i, 0, 2'd0, 16'h0);
    endtask

    task automatic add(input int id, input int n);
        for (int k = 0; k < n; k++) pat.push_back(id);
    endtask

    task automatic model_reset();
        sb.delete();
        exp_out = '0;
        sb.push_back(exp_out);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One cycle per pattern entry: pattern value is the requester expected
    // to get ready this cycle (-1 = none). Entered and left just after a negedge.
    task automatic run_pat(input string name);
        out_t       got;
        out_t       want;
        logic [3:0] rdy;
        logic [3:0] exp_rdy;
        logic [3:0] hs;
        int         e;
        while (pat.size() > 0) begin
            e = pat.pop_front();
            apply_inputs();
            #1;
            got = use1 ? {sel1, val1, id1, busy1} : {sel4, val4, id4, busy4};
            rdy = use1 ? rdy1 : rdy4;
            if (sb.size() > 0) begin
                want = sb.pop_front();
                check_eq($sformatf("%s sel", name),   32'(got.sel),   32'(want.sel));
                check_eq($sformatf("%s value", name), 32'(got.value), 32'(want.value));
                check_eq($sformatf("%s id", name),    32'(got.id),    32'(want.id));
                check_eq($sformatf("%s busy", name),  32'(got.busy),  32'(want.busy));
            end
            exp_rdy = (e >= 0) ? (4'b0001 << e) : 4'b0000;
            check_eq($sformatf("%s ready", name), 32'(rdy), 32'(exp_rdy));
            if (e >= 0) begin
                exp_out.sel   = sl[e];
                exp_out.value = dat[e];
                exp_out.id    = 2'(e);
                exp_out.busy  = 1'b1;
            end else begin
                exp_out.busy  = 1'b0;
            end
            sb.push_back(exp_out);
            hs = req_valid & rdy;
            @(posedge clk);
            advance(hs);
            @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] hs;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        use1   = 1'b0;
`ifdef DMUX_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        clear_reqs();
        apply_inputs();
        do_reset();

        // Idle after reset: everything stays zero.
        add(-1, 10);
        run_pat("idle");
`ifdef DMUX_ARB_STATS_EN
        for (int i = 0; i < 4; i++) check_eq("stats after reset", 32'(gc4[i]), 32'd0);
`endif

        // Single beat from requester 1, then outputs hold.
        set_req(1, 1, 2'd2, 16'hABCD);
        add(1, 1);
        add(-1, 4);
        run_pat("single");

        // MaxBurst=1: strict rotation, no bubbles.
        use1 = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8, 2'(i), {4'(i), 12'h100});
        for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) add(i, 1);
        run_pat("rr1");

        // MaxBurst=4: four beats per owner, busy stays high.
        use1 = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8, 2'(3 - i), {4'(i), 12'h200});
        for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) add(i, 4);
        run_pat("burst4");
`ifdef DMUX_ARB_STATS_EN
        for (int i = 0; i < 4; i++) check_eq("stats burst4", 32'(gc4[i]), 32'd8);
`endif

        // Owner 0 drops after 2 beats while 2 waits: 2 granted in the same cycle.
        do_reset();
        clear_reqs();
        set_req(0, 2, 2'd1, 16'h3000);
        set_req(2, 3, 2'd3, 16'h3200);
        pat.push_back(0); pat.push_back(0);
        pat.push_back(2); pat.push_back(2); pat.push_back(2);
        pat.push_back(-1);
        run_pat("drop");
        // Pointer now sits past requester 2: search starts at 3.
        set_req(0, 1, 2'd0, 16'h3400);
        set_req(1, 1, 2'd1, 16'h3500);
        set_req(3, 1, 2'd2, 16'h3700);
        pat.push_back(3); pat.push_back(0); pat.push_back(1); pat.push_back(-1);
        run_pat("ptr3");

        // Requester 0 ends its burst alone: pointer 1 puts requester 1 ahead of 0.
        do_reset();
        clear_reqs();
        set_req(0, 2, 2'd2, 16'h4000);
        pat.push_back(0); pat.push_back(0); pat.push_back(-1);
        run_pat("ptr1a");
        set_req(0, 1, 2'd3, 16'h4100);
        set_req(1, 1, 2'd1, 16'h4200);
        pat.push_back(1); pat.push_back(0); pat.push_back(-1);
        run_pat("ptr1b");

        // Reset in the middle of a burst.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8, 2'(i + 1), {4'(i), 12'h500});
        add(0, 2);
        run_pat("preburst");
        apply_inputs();
        rst_n = 1'b0;
        #1;
        check_eq("rst sel",   32'(sel4),  32'd0);
        check_eq("rst value", 32'(val4),  32'd0);
        check_eq("rst id",    32'(id4),   32'd0);
        check_eq("rst busy",  32'(busy4), 32'd0);
        check_eq("rst ready", 32'(rdy4),  32'd0);
        hs = req_valid & rdy4;
        @(posedge clk);
        advance(hs);
        @(negedge clk);
        check_eq("rst no accept", 32'(rem[0]), 32'd6);
        rem[0] = 0;
        rst_n  = 1'b1;
        model_reset();
        add(1, 4);
        add(2, 1);
        run_pat("postrst");

`ifdef DMUX_ARB_STATS_EN
        // Counter saturation and clear priority.
        do_reset();
        for (int i = 0; i < 4; i++) check_eq("stats cleared dut4", 32'(gc4[i]), 32'd0);
        for (int i = 0; i < 4; i++) check_eq("stats cleared dut1", 32'(gc1[i]), 32'd0);
        clear_reqs();
        set_req(3, 70000, 2'd3, 16'h0);
        for (int c = 0; c < 70100 && rem[3] > 0; c++) begin
            apply_inputs();
            #1;
            hs = req_valid & rdy4;
            @(posedge clk);
            advance(hs);
            @(negedge clk);
        end
        check_eq("sat all beats taken", 32'(rem[3]), 32'd0);
        check_eq("sat cnt3", 32'(gc4[3]), 32'hFFFF);
        check_eq("sat cnt0", 32'(gc4[0]), 32'd0);
        rem[3] = 5;
        apply_inputs();
        stats_clr = 1'b1;
        #1;
        check_eq("clr beat offered", 32'(rdy4), 32'b1000);
        hs = req_valid & rdy4;
        @(posedge clk);
        advance(hs);
        @(negedge clk);
        stats_clr = 1'b0;
        check_eq("clr beats inc", 32'(gc4[3]), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
